// File: rtl/projection_router.sv
// Projection router: z-window check and phi-region steering of 54-bit projection
// words into four sequentially addressed region memories, with per-event counts.
module projection_router #(
  parameter int unsigned        DEPTH_BITS = 6,
  parameter logic signed [11:0] ZMIN       = -12'sd1800,
  parameter logic signed [11:0] ZMAX       = 12'sd1800
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        proj_valid,
  input  logic [53:0]                 proj_in,
  output logic [3:0]                  wr_en,
  output logic [DEPTH_BITS-1:0]       wr_addr,
  output logic [53:0]                 wr_data,
  output logic [4*(DEPTH_BITS+1)-1:0] nproj,
  output logic [3:0]                  overflow,
  output logic                        z_reject
);
  localparam int unsigned   CW   = DEPTH_BITS + 1;
  localparam logic [CW-1:0] FULL = {1'b1, {DEPTH_BITS{1'b0}}};

  logic [CW-1:0]         cnt_q    [4];
  logic [CW-1:0]         cnt_d    [4];
  logic [CW-1:0]         cnt_base [4];
  logic [3:0]            ovf_q, ovf_d, ovf_base;
  logic [4*CW-1:0]       nproj_q, nproj_d;
  logic [3:0]            ovfo_q, ovfo_d;

  logic                  s1_acc_q, s1_acc_d;
  logic                  s1_rej_q, s1_rej_d;
  logic [1:0]            s1_reg_q;
  logic [DEPTH_BITS-1:0] s1_addr_q, s1_addr_d;
  logic [53:0]           s1_data_q;

  logic [3:0]            wr_en_q;
  logic [DEPTH_BITS-1:0] wr_addr_q;
  logic [53:0]           wr_data_q;
  logic                  z_reject_q;

  logic [1:0]            region;
  logic signed [11:0]    izproj;
  logic                  z_ok;

  always_comb begin
    region = proj_in[53:52];
    izproj = $signed(proj_in[39:28]);
    z_ok   = (izproj >= ZMIN) && (izproj <= ZMAX);

    // On start the counts are reported, then the same-cycle word allocates from zero.
    for (int unsigned r = 0; r < 4; r++) begin
      cnt_base[r] = start ? '0 : cnt_q[r];
      cnt_d[r]    = cnt_base[r];
    end
    ovf_base = start ? '0 : ovf_q;
    ovf_d    = ovf_base;

    nproj_d = nproj_q;
    ovfo_d  = ovfo_q;
    if (start) begin
      for (int unsigned r = 0; r < 4; r++) begin
        nproj_d[r*CW +: CW] = cnt_q[r];
      end
      ovfo_d = ovf_q;
    end

    s1_acc_d  = 1'b0;
    s1_rej_d  = 1'b0;
    s1_addr_d = cnt_base[region][DEPTH_BITS-1:0];
    if (proj_valid) begin
      if (!z_ok) begin
        s1_rej_d = 1'b1;
      end else if (cnt_base[region] == FULL) begin
        ovf_d[region] = 1'b1;
      end else begin
        s1_acc_d      = 1'b1;
        cnt_d[region] = cnt_base[region] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned r = 0; r < 4; r++) begin
        cnt_q[r] <= '0;
      end
      ovf_q      <= '0;
      nproj_q    <= '0;
      ovfo_q     <= '0;
      s1_acc_q   <= 1'b0;
      s1_rej_q   <= 1'b0;
      s1_reg_q   <= '0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      wr_en_q    <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      z_reject_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      nproj_q    <= nproj_d;
      ovfo_q     <= ovfo_d;
      s1_acc_q   <= s1_acc_d;
      s1_rej_q   <= s1_rej_d;
      s1_reg_q   <= region;
      s1_addr_q  <= s1_addr_d;
      s1_data_q  <= proj_in;
      wr_en_q    <= s1_acc_q ? (4'b0001 << s1_reg_q) : '0;
      z_reject_q <= s1_rej_q;
      // Address/data only move on a real write so they stay quiet otherwise.
      if (s1_acc_q) begin
        wr_addr_q <= s1_addr_q;
        wr_data_q <= s1_data_q;
      end
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign nproj    = nproj_q;
  assign overflow = ovfo_q;
  assign z_reject = z_reject_q;
endmodule

// File: doc/projection_router.md
# projection_router

Projection router: the stage directly downstream of projection calculation. Each cycle it takes one 54-bit projection word and range-checks its z projection. It then steers the word into one of four phi-region projection memories, writing to a per-region sequential address. Per-event entry counts and overflow flags go to the downstream matching stage. Event boundaries are marked by a `start` pulse.

## Interface
- DEPTH_BITS, 6, address width of each region memory (64 entries)
- ZMIN, -12'sd1800, lowest accepted izproj (signed, inclusive)
- ZMAX, 12'sd1800, highest accepted izproj (signed, inclusive)

- clk  input  1  clock, all logic on rising edge
- reset_n  input  1  synchronous, active-low reset
- start  input  1  one-cycle pulse marking the first cycle of a new event
- proj_valid  input  1  proj_in valid this cycle
- proj_in  input  54  projection word: [53:40] iphiproj (unsigned), [39:28] izproj (signed), [27:21] iphider (signed), [20:11] izder (signed), [10:0] tracklet index
- wr_en  output  4  one-hot region memory write enable
- wr_addr  output  DEPTH_BITS  write address in the selected region memory
- wr_data  output  54  projection word, unmodified
- nproj  output  4*(DEPTH_BITS+1)  entry counts of the previous event, region r at [r*7+6:r*7]
- overflow  output  4  per-region sticky overflow of the previous event
- z_reject  output  1  pulse: a valid word was dropped by the z window

## Operation
- Region select: r = iphiproj[13:12].
- z check: accepted iff ZMIN <= izproj <= ZMAX, signed compare on 12 bits. Rejected words produce no write and a z_reject pulse. They do not count.
- Per-region counters cnt[r] are DEPTH_BITS+1 bits wide.
- Address allocation happens in the input cycle:
  - accepted word with cnt[r] < 2^DEPTH_BITS: addr = cnt[r][DEPTH_BITS-1:0], cnt[r] increments.
  - cnt[r] == 2^DEPTH_BITS: word is dropped with no write, ovf[r] is set, cnt[r] holds at 64.
- start cycle:
  - nproj latches the cnt values and overflow latches the ovf values, both as they stood before this cycle.
  - All cnt and ovf clear.
  - A valid word in the same cycle belongs to the new event. It gets address 0 and leaves cnt[r] = 1.
- Words already allocated before start complete their write unaffected.
- Packing: nproj and overflow update only on start; between starts they hold.
- z-rejected words never set ovf, even when their region is full.

## Timing
- Two-stage pipeline:
  - Stage 1 registers the word, region, address and accept/reject decision at the edge that samples proj_in.
  - Stage 2 registers wr_en, wr_addr, wr_data and z_reject.
- Latency: word sampled at edge N appears on the write outputs after edge N+1, i.e. visible during the cycle following edge N+1.
- Throughput: one word per cycle, no backpressure. proj_valid may be high every cycle.
- nproj and overflow update at the edge that samples start, one edge ahead of the write of any same-cycle word.
- Reset, when reset_n is low at an edge:
  - Outputs: wr_en=0, wr_addr=0, wr_data=0, nproj=0, overflow=0, z_reject=0.
  - State: cnt=0, ovf=0, pipeline valid bits cleared.
  - In-flight words are discarded.
  - Reset overrides start and proj_valid in the same cycle.
- wr_addr and wr_data are don't-care when wr_en==0, but hold their last value (no toggling).

## Test plan
- Reset then start, followed by three valid words with iphiproj=0x0100, 0x1100 and 0x1200 (izproj=0):
  - wr_en=0001 addr 0, then 0010 addr 0, then 0010 addr 1, each 2 edges after input.
  - Next start gives nproj region0=1, region1=2, regions 2–3=0.
- z window, region 3: izproj=0x708 (1800) is written; izproj=0x709 (1801) and 0x8F7 (-1801) give z_reject pulses and no wr_en. Next start reports nproj[r3]=1.
- Overflow: 66 accepted words to region 2 in one event.
  - Addresses 0..63 are written; words 65–66 produce no wr_en.
  - Next start reports nproj[r2]=64 and overflow=0100, which clear for the following event.
- start coincident with valid (region 0) right after 5 region-0 words:
  - Reported nproj[r0]=5.
  - The coincident word is written at addr 0.
  - Old words 4 and 5 still complete at addrs 3 and 4.
- reset_n low mid-stream, one cycle after a valid input: no wr_en for that word, all outputs 0. After release and start, the first region-1 word is written at addr 0.
- Back-to-back 100 random valid words: a scoreboard checks per-region address order, the data match, and the nproj totals.
